// File: rtl/nand_share_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nand_share_pkg : shared types/constants for nand_share_arbiter       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package nand_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    HOLD = 2'b10
  } state_e;

  localparam int OP_CNT_W = 8;

  // Requester index width; never below one bit so ports stay legal.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nand_share_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nand_share_arbiter_if : request/response bundle for the arbiter      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface nand_share_arbiter_if
  import nand_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 1
) ();

  localparam int ID_W = id_width(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [WIDTH-1:0]       rsp_y;
  logic [ID_W-1:0]        rsp_id;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_id
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_id
  );

endinterface
`default_nettype wire

// File: rtl/nand_share_arbiter_rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_picker : combinational round-robin winner search from ptr         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_picker
  import nand_share_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  wire logic [N_REQ-1:0]              valid_i,
  input  wire logic [id_width(N_REQ)-1:0]    ptr_i,
  output logic      [N_REQ-1:0]              grant_o,
  output logic      [id_width(N_REQ)-1:0]    idx_o,
  output logic                               any_o
);

  localparam int ID_W = id_width(N_REQ);

  logic [ID_W-1:0] w_cand;

  // Scan from the farthest offset back to ptr so the closest valid wins last.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    w_cand  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_cand = ID_W'((int'(ptr_i) + k) % N_REQ);
      if (valid_i[w_cand]) begin
        grant_o         = '0;
        grant_o[w_cand] = 1'b1;
        idx_o           = w_cand;
        any_o           = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/nand_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nand_share_arbiter : round-robin time-share of one bitwise NAND unit |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module nand_share_arbiter
  import nand_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 1
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  nand_share_arbiter_if.slave      bus,
  output logic                     busy,
  output logic [OP_CNT_W-1:0]      op_count
);

  localparam int ID_W = id_width(N_REQ);

  state_e                state_q, state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [WIDTH-1:0]      opa_q, opa_d;
  logic [WIDTH-1:0]      opb_q, opb_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [WIDTH-1:0]      rsp_y_q, rsp_y_d;
  logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [OP_CNT_W-1:0]   op_count_q, op_count_d;

  logic [N_REQ-1:0]      w_grant;
  logic [ID_W-1:0]       w_idx;
  logic                  w_any;
  logic [N_REQ-1:0]      w_ready;
  logic [WIDTH-1:0]      w_a_arr [N_REQ];
  logic [WIDTH-1:0]      w_b_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_a_arr[gi] = bus.req_a[gi*WIDTH +: WIDTH];
    assign w_b_arr[gi] = bus.req_b[gi*WIDTH +: WIDTH];
  end

  rr_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .valid_i (bus.req_valid),
    .ptr_i   (ptr_q),
    .grant_o (w_grant),
    .idx_o   (w_idx),
    .any_o   (w_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      id_q        <= '0;
      rsp_y_q     <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      id_q        <= id_d;
      rsp_y_q     <= rsp_y_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    id_d        = id_q;
    rsp_y_d     = rsp_y_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    op_count_d  = op_count_q;
    w_ready     = '0;
    case (state_q)
      IDLE: begin
        if (w_any) begin
          w_ready = w_grant;
          opa_d   = w_a_arr[w_idx];
          opb_d   = w_b_arr[w_idx];
          id_d    = w_idx;
          ptr_d   = (w_idx == ID_W'(N_REQ - 1)) ? '0 : w_idx + ID_W'(1);
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_y_d     = ~(opa_q & opb_q);
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + OP_CNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gate with rst_n so nothing is offered while reset is held.
  assign bus.req_ready = rst_n ? w_ready : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_id    = rsp_id_q;
  assign busy          = rst_n & (state_q != IDLE);
  assign op_count      = op_count_q;

endmodule
`default_nettype wire

// File: tb/tb_nand_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_nand_share_arbiter : directed self-checking bench                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_nand_share_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy1, busy4;
  logic [7:0] opc1, opc4;
  int         errors = 0;
  int         checks = 0;

  nand_share_arbiter_if #(.N_REQ(4), .WIDTH(1)) if1 ();
  nand_share_arbiter_if #(.N_REQ(4), .WIDTH(4)) if4 ();

  nand_share_arbiter #(.N_REQ(4), .WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1), .busy(busy1), .op_count(opc1)
  );
  nand_share_arbiter #(.N_REQ(4), .WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4), .busy(busy4), .op_count(opc4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One requester-2 operation on the 1-bit instance; operands flip after grant.
  task automatic tt_op(input logic a, input logic b, input logic y);
    if1.req_valid = 4'b0100;
    if1.req_a     = {1'b0, a, 2'b00};
    if1.req_b     = {1'b0, b, 2'b00};
    #1 chk("tt_grant_ready", {28'd0, if1.req_ready}, 32'h4);
    tick();
    if1.req_valid = 4'b0000;
    if1.req_a     = ~if1.req_a;
    if1.req_b     = ~if1.req_b;
    chk("tt_exec_rsp_valid", {31'd0, if1.rsp_valid}, 32'd0);
    chk("tt_exec_busy", {31'd0, busy1}, 32'd1);
    tick();
    chk("tt_rsp_valid", {31'd0, if1.rsp_valid}, 32'd1);
    chk("tt_rsp_y", {31'd0, if1.rsp_y}, {31'd0, y});
    chk("tt_rsp_id", {30'd0, if1.rsp_id}, 32'd2);
    tick();
    chk("tt_rsp_drop", {31'd0, if1.rsp_valid}, 32'd0);
  endtask

  initial begin
    if1.req_valid = 4'hF; if1.req_a = '0; if1.req_b = '0; if1.rsp_ready = 1'b1;
    if4.req_valid = 4'h0; if4.req_a = '0; if4.req_b = '0; if4.rsp_ready = 1'b1;

    // Reset held for two edges with every requester asking.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_req_ready", {28'd0, if1.req_ready}, 32'd0);
      chk("rst_rsp_valid", {31'd0, if1.rsp_valid}, 32'd0);
      chk("rst_rsp_y", {31'd0, if1.rsp_y}, 32'd0);
      chk("rst_rsp_id", {30'd0, if1.rsp_id}, 32'd0);
      chk("rst_busy", {31'd0, busy1}, 32'd0);
      chk("rst_op_count", {24'd0, opc1}, 32'd0);
    end
    rst_n = 1'b1;
    if1.req_valid = 4'h0;
    tick();

    // NAND truth table through requester 2.
    tt_op(1'b0, 1'b0, 1'b1);
    tt_op(1'b0, 1'b1, 1'b1);
    tt_op(1'b1, 1'b0, 1'b1);
    tt_op(1'b1, 1'b1, 1'b0);
    chk("tt_op_count", {24'd0, opc1}, 32'd4);

    // Short reset to bring ptr back to 0 before the fairness run.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst2_op_count", {24'd0, opc1}, 32'd0);

    // Fairness: all valid, A=0101 B=1111 so requester i yields y = i[0].
    if1.req_valid = 4'hF;
    if1.req_a     = 4'b0101;
    if1.req_b     = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1 chk("fair_grant", {28'd0, if1.req_ready}, 32'd1 << (k % 4));
      tick();
      chk("fair_exec_ready", {28'd0, if1.req_ready}, 32'd0);
      tick();
      chk("fair_rsp_id", {30'd0, if1.rsp_id}, k % 4);
      chk("fair_rsp_y", {31'd0, if1.rsp_y}, (k % 4) % 2);
      tick();
    end
    chk("fair_op_count", {24'd0, opc1}, 32'd6);

    // Backpressure on requester 2's result.
    if1.rsp_ready = 1'b0;
    #1 chk("bp_grant", {28'd0, if1.req_ready}, 32'h4);
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_rsp_valid", {31'd0, if1.rsp_valid}, 32'd1);
      chk("bp_rsp_y", {31'd0, if1.rsp_y}, 32'd0);
      chk("bp_rsp_id", {30'd0, if1.rsp_id}, 32'd2);
      chk("bp_req_ready", {28'd0, if1.req_ready}, 32'd0);
      chk("bp_busy", {31'd0, busy1}, 32'd1);
      tick();
    end
    if1.rsp_ready = 1'b1;
    #1 chk("bp_accept_valid", {31'd0, if1.rsp_valid}, 32'd1);
    tick();
    chk("bp_after_valid", {31'd0, if1.rsp_valid}, 32'd0);
    chk("bp_resume_grant", {28'd0, if1.req_ready}, 32'h8);
    chk("bp_op_count", {24'd0, opc1}, 32'd7);
    tick();
    if1.req_valid = 4'h0;
    tick();
    chk("bp_next_id", {30'd0, if1.rsp_id}, 32'd3);
    chk("bp_next_y", {31'd0, if1.rsp_y}, 32'd1);
    tick();
    chk("bp_op_count2", {24'd0, opc1}, 32'd8);

    // Reset in HOLD after granting requester 1; ptr would otherwise favour 3.
    if1.req_valid = 4'b0010;
    if1.rsp_ready = 1'b0;
    #1 chk("mr_grant", {28'd0, if1.req_ready}, 32'h2);
    tick();
    if1.req_valid = 4'b0000;
    tick();
    chk("mr_hold_valid", {31'd0, if1.rsp_valid}, 32'd1);
    chk("mr_hold_id", {30'd0, if1.rsp_id}, 32'd1);
    rst_n = 1'b0;
    if1.req_valid = 4'b1001;
    #1 chk("mr_rst_ready", {28'd0, if1.req_ready}, 32'd0);
    chk("mr_rst_busy", {31'd0, busy1}, 32'd0);
    tick();
    chk("mr_rsp_valid", {31'd0, if1.rsp_valid}, 32'd0);
    chk("mr_op_count", {24'd0, opc1}, 32'd0);
    chk("mr_rsp_id", {30'd0, if1.rsp_id}, 32'd0);
    rst_n = 1'b1;
    if1.rsp_ready = 1'b1;
    #1 chk("mr_first_grant", {28'd0, if1.req_ready}, 32'h1);
    tick();
    if1.req_valid = 4'h0;
    tick();
    chk("mr_first_id", {30'd0, if1.rsp_id}, 32'd0);
    tick();
    chk("mr_op_count1", {24'd0, opc1}, 32'd1);

    // 4-bit instance: slice 3, A=1100 B=1010, then wrap op_count.
    if4.req_valid = 4'b1000;
    if4.req_a     = 16'hC000;
    if4.req_b     = 16'hA000;
    for (int op = 0; op < 256; op++) begin
      tick();
      tick();
      if (op == 0) begin
        chk("w4_rsp_y", {28'd0, if4.rsp_y}, 32'h7);
        chk("w4_rsp_id", {30'd0, if4.rsp_id}, 32'd3);
      end
      tick();
      if (op == 254) chk("w4_op_count_255", {24'd0, opc4}, 32'd255);
      if (op == 255) chk("w4_op_count_wrap", {24'd0, opc4}, 32'd0);
    end
    if4.req_valid = 4'h0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nand_share_arbiter.md
Name: nand_share_arbiter

Overview:
Time-shares one bitwise NAND evaluation unit among N_REQ requesters.
- Round-robin arbitration.
- Per-requester valid/ready request handshake.
- A single registered response channel with valid/ready, tagged with the requester id.
- Sits between the user-logic request sources and the NAND datapath inside the project's tt_um top.

Parameters:
- N_REQ, 4, number of requesters; 2..8.
- WIDTH, 1, operand width in bits; the NAND is applied bitwise.
- ID_W, $clog2(N_REQ), width of rsp_id; derived, not overridden.

Ports:
- clk  input  1  the single clock; all state changes on its rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- req_valid  input  N_REQ  bit i: requester i has an operand pair.
- req_ready  output  N_REQ  one-hot grant/accept; the handshake completes when valid[i] & ready[i].
- req_a  input  N_REQ*WIDTH  operand A; slice i belongs to requester i.
- req_b  input  N_REQ*WIDTH  operand B; slice i belongs to requester i.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_y  output  WIDTH  ~(A & B) of the granted pair.
- rsp_id  output  ID_W  index of the requester that owns rsp_y.
- busy  output  1  high whenever state != IDLE.
- op_count  output  8  number of completed response handshakes, mod 256.

Behaviour:
- FSM states: IDLE, EXEC, HOLD.
- IDLE:
  - req_ready is one-hot to the winner and is combinational from req_valid and ptr.
  - The winner is the first i with req_valid[i], searching ptr, ptr+1, … modulo N_REQ.
  - If no valid is asserted, req_ready = 0 and the FSM stays in IDLE.
  - On grant g:
    - capture req_a[g] and req_b[g] into the operand registers;
    - capture g into the id register;
    - set ptr <= (g+1) mod N_REQ;
    - go to EXEC.
- EXEC:
  - req_ready = 0.
  - Register rsp_y <= ~(opa & opb) and rsp_id <= id.
  - Assert rsp_valid from the next cycle; go to HOLD.
- HOLD:
  - rsp_valid = 1, with rsp_y and rsp_id stable; req_ready = 0.
  - On rsp_valid & rsp_ready: op_count increments, rsp_valid goes 0 next cycle, and the FSM goes to IDLE.
  - Otherwise the FSM stays in HOLD indefinitely (backpressure).
- Latency: a grant in cycle T gives rsp_valid high from T+2.
  - Minimum of 3 cycles per operation when rsp_ready is held 1.
  - The next grant can occur at T+3.
- Requesters must not make req_valid depend on req_ready. A requester may drop req_valid without a grant; nothing is captured in that case.
- Operands are sampled only in the grant cycle. Later changes on req_a/req_b do not affect the in-flight result.
- Simultaneous valids: exactly one grant per IDLE cycle; the losers keep waiting.
- With all requesters valid continuously, the grant order is ptr, ptr+1, …, so no requester waits more than N_REQ grants.
- op_count wraps from 255 to 0.
- Reset (rst_n = 0 at a clock edge, in any state, including mid-EXEC or mid-HOLD):
  - state <= IDLE, ptr <= 0;
  - rsp_valid, rsp_y, rsp_id, op_count, operand and id registers <= 0;
  - busy = 0, req_ready = 0 while rst_n = 0.
  - Any in-flight result is discarded, not delivered.
- Unused bits: none. Every input slice is used when its requester is granted.

Decomposition:
- Package nand_share_pkg:
  - state encoding constants IDLE = 2'b00, EXEC = 2'b01, HOLD = 2'b10;
  - op_count width constant (8);
  - a helper function for ID_W.
- Sub-module rr_picker(N_REQ): combinational, taking req_valid and ptr and producing a one-hot grant plus a binary index. This is the only sub-module.
- The NAND itself is one inline bitwise expression in the EXEC register stage; no instance.

Test Plan:
1. Reset: rst_n = 0 for 2 cycles with all req_valid = 1 → req_ready = 0, rsp_valid = 0, rsp_y = 0, rsp_id = 0, busy = 0, op_count = 0 throughout.
2. Truth table, WIDTH = 1, requester 2 only, rsp_ready = 1, pairs (0,0), (0,1), (1,0), (1,1):
   - req_ready[2] in the grant cycle T; rsp_valid at T+2; rsp_id = 2;
   - rsp_y = 1, 1, 1, 0;
   - op_count = 4.
3. Fairness: all 4 valid continuously, rsp_ready = 1 → grants 0, 1, 2, 3, 0, 1 at cycles T, T+3, T+6, …; rsp_id follows the same sequence.
4. Backpressure: rsp_ready = 0 for 5 cycles after rsp_valid rises → rsp_valid, rsp_y and rsp_id are stable, req_ready = 0, busy = 1; a grant resumes the cycle after the accept plus one.
5. Reset mid-HOLD after granting requester 1, with requesters 0 and 3 then valid → the next cycle shows rsp_valid = 0 and op_count = 0; the first grant after reset goes to requester 0.
6. WIDTH = 4, op_count wrap: A = 4'b1100, B = 4'b1010 → rsp_y = 4'b0111; after 256 accepted operations op_count = 0.
